seq_shifter_n_bit: RTL and testbench

Multi-cycle, parametrised shift unit for the ALU. It succeeds the single-cycle right-only shifter. It supports logical left, logical right, arithmetic right and rotate right, and moves up to STRIDE bit positions per clock. A start/busy/done handshake lets the control unit trade latency for area. Outputs are the registered result and N/Z/V/C flags, in the same flag ordering the rest of the ALU consumes.

---
 rtl/shifter_pkg.sv | 21 ++
 rtl/shift_step_n_bit.sv | 54 +++++
 rtl/seq_shifter_n_bit.sv | 131 +++++++++++++
 tb/tb_seq_shifter_n_bit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings for the multi-cycle shift unit: op modes, FSM states, flag bit positions.
package shifter_pkg;

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_LSL = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/shift_step_n_bit.sv
// Combinational single-step shifter: moves value by step positions in the given mode and
// reports the last bit shifted out plus whether the resulting MSB differs from sign.
module shift_step_n_bit
    import shifter_pkg::*;
#(
    parameter int unsigned SIZE   = 16,
    parameter int unsigned STEP_W = 1
) (
    input  logic [SIZE-1:0]   value_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [1:0]        op_i,
    input  logic              sign_i,
    output logic [SIZE-1:0]   result_o,
    output logic              out_bit_o,
    output logic              msb_changed_o
);

    logic [2*SIZE-1:0] ext;
    int                s;

    always_comb begin
        ext       = '0;
        result_o  = value_i;
        out_bit_o = 1'b0;
        s         = int'(step_i);

        case (op_i)
            OP_LSL: result_o = value_i << step_i;
            OP_LSR: result_o = value_i >> step_i;
            OP_ASR: begin
                ext      = {{SIZE{sign_i}}, value_i} >> step_i;
                result_o = ext[SIZE-1:0];
            end
            default: begin
                ext      = {value_i, value_i} >> step_i;
                result_o = ext[SIZE-1:0];
            end
        endcase

        // Last bit out: top side for left shifts, bottom side for everything else.
        for (int k = 0; k < int'(SIZE); k++) begin
            if (s != 0) begin
                if (op_i == OP_LSL) begin
                    if (k == int'(SIZE) - s) out_bit_o = value_i[k];
                end else begin
                    if (k == s - 1) out_bit_o = value_i[k];
                end
            end
        end

        msb_changed_o = result_o[SIZE-1] ^ sign_i;
    end

endmodule

// File: rtl/seq_shifter_n_bit.sv
// Multi-cycle shift unit (LSR/LSL/ASR/ROR), up to STRIDE positions per clock, with a
// start/busy/done handshake and registered N/Z/V/C flags.
module seq_shifter_n_bit
    import shifter_pkg::*;
#(
    parameter int unsigned SIZE   = 16,
    parameter int unsigned M      = 4,
    parameter int unsigned STRIDE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [SIZE-1:0] in_a,
    input  logic [M-1:0]    shift,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] out,
    output logic [3:0]      flags_n_z_v_c
);

    localparam int unsigned STEP_W = $clog2(STRIDE + 1);

    state_e              state_q, state_d;
    logic [M-1:0]        rem_q, rem_d;
    logic [SIZE-1:0]     work_q, work_d;
    logic [1:0]          op_q, op_d;
    logic                sign_q, sign_d;
    logic                v_q, v_d;
    logic                c_q, c_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    logic [STEP_W-1:0]   step;
    logic [SIZE-1:0]     step_result;
    logic                step_out_bit;
    logic                step_msb_changed;

    always_comb begin
        if (32'(rem_q) < STRIDE) step = STEP_W'(rem_q);
        else                     step = STEP_W'(STRIDE);
    end

    shift_step_n_bit #(
        .SIZE   (SIZE),
        .STEP_W (STEP_W)
    ) u_step (
        .value_i       (work_q),
        .step_i        (step),
        .op_i          (op_q),
        .sign_i        (sign_q),
        .result_o      (step_result),
        .out_bit_o     (step_out_bit),
        .msb_changed_o (step_msb_changed)
    );

    // Next-state, datapath and flag update.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        work_d  = work_q;
        op_d    = op_q;
        sign_d  = sign_q;
        v_d     = v_q;
        c_d     = c_q;
        flags_d = flags_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    work_d = in_a;
                    rem_d  = shift;
                    op_d   = op;
                    sign_d = in_a[SIZE-1];
                    v_d    = 1'b0;
                    c_d    = 1'b0;
                    if (shift != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d         = ST_DONE;
                        flags_d         = '0;
                        flags_d[FLAG_N] = in_a[SIZE-1];
                        flags_d[FLAG_Z] = ~|in_a;
                    end
                end
            end
            ST_RUN: begin
                work_d = step_result;
                rem_d  = rem_q - M'(step);
                c_d    = step_out_bit;
                v_d    = v_q | ((op_q == OP_LSL) & step_msb_changed);
                if (rem_d == '0) begin
                    state_d         = ST_DONE;
                    flags_d[FLAG_N] = work_d[SIZE-1];
                    flags_d[FLAG_Z] = ~|work_d;
                    flags_d[FLAG_V] = v_d;
                    flags_d[FLAG_C] = c_d;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            work_q  <= '0;
            op_q    <= OP_LSR;
            sign_q  <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            v_q     <= v_d;
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end

    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign out           = work_q;
    assign flags_n_z_v_c = flags_q;

endmodule

// File: tb/tb_seq_shifter_n_bit.sv
// Randomized self-checking bench for seq_shifter_n_bit (STRIDE=1 and STRIDE=4 instances)
// against a bit-at-a-time reference model.
module tb_seq_shifter_n_bit;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start4;
    logic [1:0]  op1, op4;
    logic [15:0] a1, a4;
    logic [3:0]  sh1, sh4;
    logic        busy1, busy4, done1, done4;
    logic [15:0] out1, out4;
    logic [3:0]  fl1, fl4;

    int          n_err = 0;
    int          n_chk = 0;
    bit          sel = 1'b0;
    logic [15:0] last_out;
    logic [3:0]  last_fl;

    always #5 clk = ~clk;

    seq_shifter_n_bit #(.SIZE(16), .M(4), .STRIDE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .in_a(a1), .shift(sh1),
        .busy(busy1), .done(done1), .out(out1), .flags_n_z_v_c(fl1)
    );

    seq_shifter_n_bit #(.SIZE(16), .M(4), .STRIDE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .in_a(a4), .shift(sh4),
        .busy(busy4), .done(done4), .out(out4), .flags_n_z_v_c(fl4)
    );

    wire        busy_m = sel ? busy4 : busy1;
    wire        done_m = sel ? done4 : done1;
    wire [15:0] out_m  = sel ? out4  : out1;
    wire [3:0]  fl_m   = sel ? fl4   : fl1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: one bit position at a time, grouped into per-clock chunks of up to stride.
    function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [3:0] sh,
                                  input int stride, output logic [15:0] res,
                                  output logic [3:0] fl, output int ncyc);
        logic [15:0] val = a;
        logic        msb0 = a[15];
        logic        c = 1'b0;
        logic        v = 1'b0;
        int          rem = int'(sh);
        int          st;
        ncyc = 0;
        while (rem > 0) begin
            st = (rem < stride) ? rem : stride;
            for (int j = 0; j < st; j++) begin
                case (op)
                    OP_LSR:  begin c = val[0];  val = {1'b0, val[15:1]}; end
                    OP_LSL:  begin c = val[15]; val = {val[14:0], 1'b0}; end
                    OP_ASR:  begin c = val[0];  val = {msb0, val[15:1]}; end
                    default: begin c = val[0];  val = {val[0], val[15:1]}; end
                endcase
            end
            if (op == OP_LSL && val[15] != msb0) v = 1'b1;
            rem -= st;
            ncyc++;
        end
        res = val;
        fl  = {val[15], (val == 16'h0), v, c};
    endfunction

    task automatic drive(input bit st, input logic [1:0] o, input logic [15:0] a, input logic [3:0] sh);
        if (sel) begin
            start4 = st; op4 = o; a4 = a; sh4 = sh;
        end else begin
            start1 = st; op1 = o; a1 = a; sh1 = sh;
        end
    endtask

    // Issues one operation from mid-cycle; returns at the mid-point of the done cycle.
    task automatic do_op(input bit s, input logic [1:0] op, input logic [15:0] a,
                         input logic [3:0] sh, input bit poke, input string tag);
        logic [15:0] eo;
        logic [3:0]  ef;
        int          n;
        sel = s;
        model(op, a, sh, s ? 4 : 1, eo, ef, n);
        drive(1'b1, op, a, sh);
        @(posedge clk);
        #1 drive(1'b0, 2'($urandom), 16'($urandom), 4'($urandom));
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(busy_m), 32'(k <= n));
            chk({tag, "_done"}, 32'(done_m), 32'(k == n + 1));
            if (k == n + 1) begin
                chk({tag, "_out"}, 32'(out_m), 32'(eo));
                chk({tag, "_flags"}, 32'(fl_m), 32'(ef));
            end
            if (poke && k == 1 && n >= 1) begin
                drive(1'b1, 2'($urandom), 16'($urandom), 4'($urandom));
                @(posedge clk);
                #1 drive(1'b0, 2'($urandom), 16'($urandom), 4'($urandom));
            end
        end
        last_out = eo;
        last_fl  = ef;
    endtask

    task automatic idle(input int g);
        repeat (g) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy_m), 32'(0));
            chk("idle_done", 32'(done_m), 32'(0));
            chk("idle_out", 32'(out_m), 32'(last_out));
            chk("idle_flags", 32'(fl_m), 32'(last_fl));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; op1 = '0; a1 = '0; sh1 = '0;
        start4 = 1'b0; op4 = '0; a4 = '0; sh4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy1", 32'(busy1), 32'(0));
        chk("rst_done1", 32'(done1), 32'(0));
        chk("rst_out1", 32'(out1), 32'(0));
        chk("rst_flags1", 32'(fl1), 32'(0));
        chk("rst_out4", 32'(out4), 32'(0));
        chk("rst_flags4", 32'(fl4), 32'(0));
        rst_n = 1'b1;
        last_out = '0;
        last_fl  = '0;
        sel = 1'b0;
        idle(1);

        do_op(1'b0, OP_LSR, 16'h8001, 4'd1, 1'b0, "lsr");
        chk("lsr_out_k", 32'(out1), 32'h4000);
        chk("lsr_fl_k", 32'(fl1), 32'h1);
        idle(1);
        do_op(1'b0, OP_ASR, 16'h8000, 4'd15, 1'b0, "asr");
        chk("asr_out_k", 32'(out1), 32'hFFFF);
        chk("asr_fl_k", 32'(fl1), 32'h8);
        do_op(1'b0, OP_LSL, 16'h4000, 4'd1, 1'b0, "lsl");
        chk("lsl_fl_k", 32'(fl1), 32'hA);
        do_op(1'b0, OP_ROR, 16'h0001, 4'd1, 1'b0, "ror");
        chk("ror_fl_k", 32'(fl1), 32'h9);
        do_op(1'b0, OP_ROR, 16'h0000, 4'd0, 1'b0, "sh0");
        chk("sh0_fl_k", 32'(fl1), 32'h4);
        idle(2);

        sel = 1'b1;
        last_out = '0;
        last_fl  = '0;
        do_op(1'b1, OP_LSR, 16'hF000, 4'd6, 1'b1, "s4lsr");
        chk("s4lsr_out_k", 32'(out4), 32'h03C0);
        chk("s4lsr_fl_k", 32'(fl4), 32'h0);
        idle(1);

        // Asynchronous reset during RUN of a 10-step LSL.
        sel = 1'b0;
        drive(1'b1, OP_LSL, 16'h1234, 4'd10);
        @(posedge clk);
        #1 drive(1'b0, 2'd0, 16'd0, 4'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 chk("mid_busy_pre", 32'(busy1), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy1), 32'(0));
        chk("mid_done", 32'(done1), 32'(0));
        chk("mid_out", 32'(out1), 32'(0));
        chk("mid_flags", 32'(fl1), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_out = '0;
        last_fl  = '0;
        idle(2);
        do_op(1'b0, OP_LSL, 16'h0003, 4'd2, 1'b0, "post");
        chk("post_out_k", 32'(out1), 32'h000C);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                do_op(d[0], 2'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), "rnd");
                if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
            end
            idle(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
